uart_tx_arbiter: RTL

//  Round-robin arbiter and sequencer that shares one 64-bit UART frame transmitter among NUM_REQ requesters.

---
 rtl/uart_tx_arbiter_pkg.sv | 13 +
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding and default frame width.
package uart_tx_pkg;

    localparam int DATA_W_DEF = 64;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-side signals of the arbiter; master is the arbiter itself.
interface uart_tx_arbiter_if
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        I_req_valid;
    logic [NUM_REQ*DATA_W-1:0] I_req_data;
    logic [NUM_REQ-1:0]        O_req_ready;
    logic                      O_tx_valid;
    logic [DATA_W-1:0]         O_tx_data;
    logic                      I_tx_ready;
    logic                      O_busy;
    logic [2:0]                O_grant_id;
    logic                      O_err;

    modport master (
        input  I_req_valid, I_req_data, I_tx_ready,
        output O_req_ready, O_tx_valid, O_tx_data, O_busy, O_grant_id, O_err
    );

    modport slave (
        output I_req_valid, I_req_data, I_tx_ready,
        input  O_req_ready, O_tx_valid, O_tx_data, O_busy, O_grant_id, O_err
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the last grant, wrapping.
module uart_tx_arbiter_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         idx,
    output logic               any
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [3:0] pos;

    always_comb begin
        gnt = '0;
        idx = last;
        any = 1'b0;
        pos = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = {1'b0, last} + 4'(k);
            if (pos >= 4'(NUM_REQ)) pos = pos - 4'(NUM_REQ);
            if (!any && req[pos[IW-1:0]]) begin
                any                = 1'b1;
                gnt[pos[IW-1:0]]   = 1'b1;
                idx                = pos[2:0];
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART frame transmitter among NUM_REQ one-deep holding slots.
// state     | meaning
// IDLE      | waiting for a full slot and an idle transmitter
// ISSUE     | one-cycle issue strobe, winner slot released
// WAIT_ACK  | waiting for transmitter ready to fall, with timeout
// WAIT_DONE | waiting for transmitter ready to return
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACK_TO  = 64
) (
    input  logic              I_clk_10M,
    input  logic              I_rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TO - 1);

    state_t             state, state_nxt;
    logic               busy;
    logic [NUM_REQ-1:0] full, win_oh, pick_oh;
    logic [DATA_W-1:0]  slot_data [NUM_REQ];
    logic [DATA_W-1:0]  tx_data;
    logic [2:0]         grant_id, pick_idx;
    logic               pick_any;
    logic [CNT_W-1:0]   cnt;
    logic               start, timeout;

    uart_tx_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req  (full),
        .last (grant_id),
        .gnt  (pick_oh),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign start   = (state == ST_IDLE) && pick_any && bus.I_tx_ready;
    assign timeout = (state == ST_WAIT_ACK) && bus.I_tx_ready && (cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start) state_nxt = ST_ISSUE;
            ST_ISSUE:     state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!bus.I_tx_ready) state_nxt = ST_WAIT_DONE;
                else if (timeout)    state_nxt = ST_IDLE;
            end
            ST_WAIT_DONE: if (bus.I_tx_ready) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            tx_data  <= '0;
            grant_id <= 3'(NUM_REQ - 1);
            win_oh   <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            if (start) begin
                tx_data  <= slot_data[pick_idx[IW-1:0]];
                grant_id <= pick_idx;
                win_oh   <= pick_oh;
            end
            // Counter saturates at ACK_TO-1 so a stalled WAIT_ACK can never wrap.
            if (state == ST_ISSUE)
                cnt <= '0;
            else if (state == ST_WAIT_ACK && cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Release wins over capture; the winner slot is full during ISSUE so no write is lost.
    always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            full <= '0;
            for (int i = 0; i < NUM_REQ; i++) slot_data[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (state == ST_ISSUE && win_oh[i]) begin
                    full[i] <= 1'b0;
                end else if (bus.I_req_valid[i] && !full[i]) begin
                    full[i]      <= 1'b1;
                    slot_data[i] <= bus.I_req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign bus.O_req_ready = ~full;
    assign bus.O_tx_valid  = (state == ST_ISSUE);
    assign bus.O_tx_data   = tx_data;
    assign bus.O_busy      = busy;
    assign bus.O_grant_id  = grant_id;
    assign bus.O_err       = timeout;
endmodule
